// File: rtl/clock_works_pkg.sv
// clock_works_pkg: default build constants for the clock/reset front-end
package clock_works_pkg;
    localparam int SLOW_DEFAULT           = 19;
    localparam int RESET_POLARITY_DEFAULT = 1;
    localparam int RESET_HOLD_DEFAULT     = 4;
endpackage

// File: rtl/clock_works_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer, powers up cleared
module sync_2ff
    import clock_works_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta = '0;
    logic [WIDTH-1:0] sync = '0;
    // two back-to-back flops give metastability a full cycle to settle
    always_ff @(posedge clk) begin
        meta <= d;
        sync <= meta;
    end
    assign q = sync;
endmodule

// File: rtl/clock_works.sv
// clock_works: divides CLK into the core clock clk and builds a clean core reset
module clock_works
    import clock_works_pkg::*;
#(
    parameter int SLOW           = SLOW_DEFAULT,
    parameter int RESET_POLARITY = RESET_POLARITY_DEFAULT,
    parameter int RESET_HOLD     = RESET_HOLD_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic reset
);
    localparam int   HW  = $clog2(RESET_HOLD + 1);
    localparam logic POL = RESET_POLARITY[0];
    logic [SLOW:0]   div_cnt  = '0;
    logic [HW-1:0]   hold_cnt = '0;
    logic            reset_r  = 1'b1;
    logic            btn;
    logic            btn_s;
    // free-running divider; never reset so the core clock runs through reset
    always_ff @(posedge CLK)
        div_cnt <= div_cnt + (SLOW+1)'(1);
    assign clk = div_cnt[SLOW];
    assign btn = RESET ^ ~POL;
    sync_2ff #(.WIDTH(1)) u_btn_sync (
        .clk (CLK),
        .d   (btn),
        .q   (btn_s)
    );
    // press forces reset and restarts the hold; release counts out the hold first
    always_ff @(posedge clk) begin
        if (btn_s) begin
            reset_r  <= 1'b1;
            hold_cnt <= '0;
        end else if (hold_cnt != HW'(RESET_HOLD))
            hold_cnt <= hold_cnt + 1'b1;
        else
            reset_r <= 1'b0;
    end
    assign reset = reset_r;
endmodule

// File: tb/tb_clock_works.sv
// tb_clock_works: directed checks of divider timing and reset sequencing
module tb_clock_works;
    logic CLK = 1'b0;
    logic RESET0 = 1'b0, RESET1 = 1'b1, RESET2 = 1'b0;
    logic clk0, clk1, clk2, reset0, reset1, reset2;
    int   e = 0;
    int   n_chk = 0, n_err = 0;

    always #5 CLK = ~CLK;

    clock_works #(.SLOW(2), .RESET_POLARITY(1), .RESET_HOLD(4)) u0 (
        .CLK(CLK), .RESET(RESET0), .clk(clk0), .reset(reset0));
    clock_works #(.SLOW(2), .RESET_POLARITY(0), .RESET_HOLD(4)) u1 (
        .CLK(CLK), .RESET(RESET1), .clk(clk1), .reset(reset1));
    clock_works #(.SLOW(0), .RESET_POLARITY(1), .RESET_HOLD(4)) u2 (
        .CLK(CLK), .RESET(RESET2), .clk(clk2), .reset(reset2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at CLK edge %0d: got %0d expected %0d", tag, e, got, exp);
        end
    endtask

    task automatic step_to(input int n);
        while (e < n) begin
            @(posedge CLK);
            e++;
        end
        #1;
    endtask

    initial begin
        int low_seen, rbad, pbad, ntog, last;
        logic prev;
        #1;
        chk("t0_clk", clk0, 0);
        chk("t0_reset", reset0, 1);
        step_to(1);  chk("slow0_clk_e1", clk2, 1);
        step_to(2);  chk("slow0_clk_e2", clk2, 0);
        step_to(3);  chk("clk_e3", clk0, 0);
        step_to(4);  chk("clk_rise_e4", clk0, 1);
        step_to(7);  chk("clk_e7", clk0, 1);
        step_to(8);  chk("clk_fall_e8", clk0, 0);
        chk("slow0_reset_e8", reset2, 1);
        step_to(9);  chk("slow0_reset_e9", reset2, 0);
        step_to(12); chk("clk_rise_e12", clk0, 1);
        step_to(35);
        chk("pwr_reset_e35", reset0, 1);
        chk("pol0_reset_e35", reset1, 1);
        step_to(36);
        chk("pwr_reset_e36", reset0, 0);
        chk("pol0_reset_e36", reset1, 0);
        step_to(40); RESET0 = 1'b1;
        step_to(43); chk("press_e43", reset0, 0);
        step_to(44); chk("press_e44", reset0, 1);
        step_to(60); RESET0 = 1'b0;
        step_to(99);  chk("hold_e99", reset0, 1);
        step_to(100);
        chk("release_e100", reset0, 0);
        chk("clk_during_e100", clk0, 1);
        step_to(104); RESET0 = 1'b1; RESET1 = 1'b0;
        step_to(107);
        chk("bounce_e107", reset0, 0);
        chk("pol0_press_e107", reset1, 0);
        step_to(108); chk("pol0_press_e108", reset1, 1);
        low_seen = 0;
        for (int n = 108; n <= 163; n++) begin
            step_to(n);
            if (!reset0) low_seen++;
            if (n == 112) RESET0 = 1'b0;
            if (n == 120) RESET0 = 1'b1;
            if (n == 128) RESET0 = 1'b0;
        end
        chk("bounce_no_glitch", low_seen, 0);
        step_to(164);
        chk("bounce_release_e164", reset0, 0);
        RESET1 = 1'b1;
        rbad = 0; pbad = 0; ntog = 0; last = 164; prev = clk0;
        for (int n = 165; n <= 164 + 8000; n++) begin
            step_to(n);
            if (reset0) rbad++;
            if (clk0 != prev) begin
                if (n - last != 4) pbad++;
                ntog++;
                last = n;
                prev = clk0;
            end
        end
        chk("long_no_reassert", rbad, 0);
        chk("long_phase_len", pbad, 0);
        chk("long_toggles", ntog, 2000);
        chk("pol0_release_final", reset1, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
